// File: rtl/dmu_pkg.sv
// Shared definitions for the multi-cycle data memory unit.
// funct3 codes, FSM encoding and a constant log2 helper.
package dmu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } dmu_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/dmu_lane_align.sv
// Byte-lane steering for RV32 sub-word loads and stores.
// Pure combinational: enables, replicated store data, extended load data.
module dmu_lane_align
  import dmu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic        is_b;
  logic        is_h;
  logic        is_w;
  logic        sext;
  logic [7:0]  rb;
  logic [15:0] rh;

  assign is_b = (funct3 == F3_B) || (funct3 == F3_BU);
  assign is_h = (funct3 == F3_H) || (funct3 == F3_HU);
  assign is_w = (funct3 == F3_W);
  assign sext = ~funct3[2];
  assign rb   = rdata[{lane, 3'b000} +: 8];
  assign rh   = lane[1] ? rdata[31:16] : rdata[15:0];

  // Store data is replicated across lanes so byte_en alone picks the target.
  always_comb begin
    byte_en   = '0;
    wdata_sh  = '0;
    rdata_ext = '0;
    misalign  = 1'b0;
    unique case (1'b1)
      is_b: begin
        byte_en   = 4'b0001 << lane;
        wdata_sh  = {4{wdata[7:0]}};
        rdata_ext = {{24{rb[7] & sext}}, rb};
      end
      is_h: begin
        byte_en   = lane[1] ? 4'b1100 : 4'b0011;
        wdata_sh  = {2{wdata[15:0]}};
        rdata_ext = {{16{rh[15] & sext}}, rh};
        misalign  = lane[0];
      end
      is_w: begin
        byte_en   = 4'b1111;
        wdata_sh  = wdata;
        rdata_ext = rdata;
        misalign  = |lane;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmu_mc_engine.sv
// Multi-cycle data memory unit with valid/ready handshakes,
// programmable latency and RV32 sub-word access.
module dmu_mc_engine
  import dmu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic             busy
);

  localparam int AW = clog2(DEPTH);
  localparam logic [WIDTH:0] LIMIT = (WIDTH+1)'(DEPTH) << 2;

  dmu_state_t       state;
  logic [3:0]       cnt;
  logic             we_q;
  logic [2:0]       f3_q;
  logic [AW-1:0]    idx_q;
  logic [1:0]       lane_q;
  logic [WIDTH-1:0] wdata_q;
  logic             err_q;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [2:0]       sel_f3;
  logic [1:0]       sel_lane;
  logic [3:0]       byte_en;
  logic [31:0]      wdata_sh;
  logic [31:0]      rdata_ext;
  logic             misalign;
  logic             f3_ok;
  logic             oor;
  logic             acc_err;
  logic             commit;

  // In IDLE the aligner sees the incoming request for the misalign check.
  assign sel_f3   = (state == IDLE) ? req_funct3 : f3_q;
  assign sel_lane = (state == IDLE) ? req_addr[1:0] : lane_q;

  dmu_lane_align u_align (
    .funct3    (sel_f3),
    .lane      (sel_lane),
    .wdata     (wdata_q),
    .rdata     (mem[idx_q]),
    .byte_en   (byte_en),
    .wdata_sh  (wdata_sh),
    .rdata_ext (rdata_ext),
    .misalign  (misalign)
  );

  assign f3_ok = (req_funct3 == F3_B) || (req_funct3 == F3_H) ||
                 (req_funct3 == F3_W) ||
                 (!req_we && ((req_funct3 == F3_BU) ||
                              (req_funct3 == F3_HU)));
  assign oor     = {1'b0, req_addr} >= LIMIT;
  assign acc_err = !f3_ok || oor || misalign;
  assign commit  = (state == ACCESS) && (cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      f3_q      <= '0;
      idx_q     <= '0;
      lane_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (req_valid) begin
          we_q      <= req_we;
          f3_q      <= req_funct3;
          idx_q     <= req_addr[AW+1:2];
          lane_q    <= req_addr[1:0];
          wdata_q   <= req_wdata;
          err_q     <= acc_err;
          cnt       <= 4'(LATENCY);
          state     <= ACCESS;
          req_ready <= 1'b0;
          busy      <= 1'b1;
        end
        ACCESS: if (cnt != '0) begin
          cnt <= cnt - 4'd1;
        end else begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= err_q;
          rsp_rdata <= (err_q || we_q) ? '0 : rdata_ext;
        end
        RESP: if (rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (commit && we_q && !err_q) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[idx_q][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmu_mc_engine.sv
// Randomized self-checking bench for dmu_mc_engine.
// Expected values come from a byte-array model of the memory.
module tb_dmu_mc_engine;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] rm [4096];

  always #5 clk = ~clk;

  dmu_mc_engine #(.WIDTH(32), .DEPTH(1024), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic ref_err(input logic we, input logic [2:0] f3,
                                   input logic [31:0] a);
    if (!(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1'b1;
    if (we && f3[2]) return 1'b1;
    if (a >= 32'd4096) return 1'b1;
    if ((a % size_of(f3)) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                           input logic [31:0] a);
    logic [31:0] v;
    int sz;
    sz = size_of(f3);
    v = '0;
    for (int i = 0; i < sz; i++) v |= 32'(rm[a + i]) << (8 * i);
    if (!f3[2] && sz < 4 && v[8*sz-1])
      v |= ~((32'd1 << (8 * sz)) - 32'd1);
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d);
    for (int i = 0; i < size_of(f3); i++) rm[a + i] = d[8*i +: 8];
  endtask

  // hold: cycles to keep rsp_ready low once the response is up.
  // poke: present a competing store during those cycles.
  task automatic txn(input logic we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] d,
                     input int hold, input bit poke);
    logic [31:0] er;
    logic        ee;
    int          n;
    ee = ref_err(we, f3, a);
    er = '0;
    if (!ee && !we) er = ref_load(f3, a);
    if (!ee && we) ref_store(f3, a, d);
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_we = we;
    req_funct3 = f3;
    req_addr = a;
    req_wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    chk("latency", 32'(n), 32'(LAT + 1));
    chk("rdata", rsp_rdata, er);
    chk("err", rsp_err, ee);
    if (poke) begin
      req_valid = 1'b1;
      req_we = 1'b1;
      req_funct3 = 3'b010;
      req_addr = 32'h14;
      req_wdata = 32'hCAFEF00D;
    end
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      chk("stall_valid", rsp_valid, 1);
      chk("stall_rdata", rsp_rdata, er);
      chk("stall_err", rsp_err, ee);
      chk("stall_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk("rsp_drop", rsp_valid, 0);
    if (poke) begin
      @(posedge clk);
      #1 chk("poke_busy", busy, 0);
    end
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    logic [2:0]  f3_pool [8];
    f3_pool = '{3'b000, 3'b001, 3'b010, 3'b100,
                3'b101, 3'b011, 3'b110, 3'b111};
    foreach (rm[i]) rm[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int w = 0; w < 16; w++)
      txn(1'b1, 3'b010, 32'(4 * w), $urandom, 0, 0);

    txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0);
    txn(1'b0, 3'b010, 32'h10, 0, 0, 0);
    txn(1'b1, 3'b000, 32'h11, 32'h000000A5, 0, 0);
    txn(1'b0, 3'b000, 32'h11, 0, 0, 0);
    txn(1'b0, 3'b100, 32'h11, 0, 0, 0);
    txn(1'b0, 3'b010, 32'h10, 0, 0, 0);
    txn(1'b1, 3'b001, 32'h12, 32'h00008001, 0, 0);
    txn(1'b0, 3'b001, 32'h12, 0, 0, 0);
    txn(1'b0, 3'b101, 32'h12, 0, 0, 0);
    txn(1'b0, 3'b010, 32'h10, 0, 0, 0);
    txn(1'b0, 3'b010, 32'h13, 0, 0, 0);
    txn(1'b1, 3'b010, 32'h1000, 32'h55AA55AA, 0, 0);
    txn(1'b0, 3'b010, 32'h0, 0, 0, 0);

    txn(1'b0, 3'b010, 32'h10, 0, 5, 1);
    txn(1'b0, 3'b010, 32'h14, 0, 0, 0);

    @(negedge clk);
    req_valid = 1'b1;
    req_we = 1'b1;
    req_funct3 = 3'b010;
    req_addr = 32'h20;
    req_wdata = 32'h12345678;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_req_ready", req_ready, 1);
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_rdata", rsp_rdata, 0);
    chk("mid_err", rsp_err, 0);
    chk("mid_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 chk("rel_req_ready", req_ready, 1);
    repeat (6) begin
      @(posedge clk);
      #1 chk("no_rsp_after_rst", rsp_valid, 0);
    end
    txn(1'b0, 3'b010, 32'h20, 0, 0, 0);

    for (int t = 0; t < 80; t++) begin
      f3 = ($urandom_range(0, 9) == 0) ? f3_pool[$urandom_range(5, 7)]
                                       : f3_pool[$urandom_range(0, 4)];
      a = ($urandom_range(0, 15) == 0) ? 32'h1000 + $urandom_range(0, 255)
                                       : 32'($urandom_range(0, 63));
      txn(1'($urandom_range(0, 1)), f3, a, $urandom,
          $urandom_range(0, 2), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
